// File: rtl/vga_scaler_pkg.sv
// Shared constants, fill FSM state type and NES master palette for the VGA line scaler.
package vga_scaler_pkg;

    localparam int X_OFFSET_DEF = 64;
    localparam int NES_W        = 256;
    localparam int NES_H        = 240;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } fillState_t;

    // 8-bit channels widened to 10 bits by replicating the top bits, so full scale stays full scale
    function automatic logic [29:0] rgb10(input logic [23:0] c);
        return {c[23:16], c[23:22], c[15:8], c[15:14], c[7:0], c[7:6]};
    endfunction

    localparam logic [29:0] NES_PALETTE [64] = '{
        rgb10(24'h7C7C7C), rgb10(24'h0000FC), rgb10(24'h0000BC), rgb10(24'h4428BC),
        rgb10(24'h940084), rgb10(24'hA80020), rgb10(24'hA81000), rgb10(24'h881400),
        rgb10(24'h503000), rgb10(24'h007800), rgb10(24'h006800), rgb10(24'h005800),
        rgb10(24'h004058), rgb10(24'h000000), rgb10(24'h000000), rgb10(24'h000000),
        rgb10(24'hBCBCBC), rgb10(24'h0078F8), rgb10(24'h0058F8), rgb10(24'h6844FC),
        rgb10(24'hD800CC), rgb10(24'hE40058), rgb10(24'hF83800), rgb10(24'hE45C10),
        rgb10(24'hAC7C00), rgb10(24'h00B800), rgb10(24'h00A800), rgb10(24'h00A844),
        rgb10(24'h008888), rgb10(24'h000000), rgb10(24'h000000), rgb10(24'h000000),
        rgb10(24'hF8F8F8), rgb10(24'h3CBCFC), rgb10(24'h6888FC), rgb10(24'h9878F8),
        rgb10(24'hF878F8), rgb10(24'hF85898), rgb10(24'hF87858), rgb10(24'hFCA044),
        rgb10(24'hF8B800), rgb10(24'hB8F818), rgb10(24'h58D854), rgb10(24'h58F898),
        rgb10(24'h00E8D8), rgb10(24'h787878), rgb10(24'h000000), rgb10(24'h000000),
        rgb10(24'hFCFCFC), rgb10(24'hA4E4FC), rgb10(24'hB8B8F8), rgb10(24'hD8B8F8),
        rgb10(24'hF8B8F8), rgb10(24'hF8A4C0), rgb10(24'hF0D0B0), rgb10(24'hFCE0A8),
        rgb10(24'hF8D878), rgb10(24'hD8F878), rgb10(24'hB8F8B8), rgb10(24'hB8F8D8),
        rgb10(24'h00FCFC), rgb10(24'hF8D8F8), rgb10(24'h000000), rgb10(24'h000000)
    };

endpackage

// File: rtl/nes_palette_rom.sv
// Registered NES palette lookup: 6-bit colour index to 30-bit RGB, forced black on blank.
module nes_palette_rom
    import vga_scaler_pkg::*;
(
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [5:0]  iIndex,
    input  logic        iBlank,
    output logic [29:0] oRgb
);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            oRgb <= '0;
        else
            oRgb <= iBlank ? 30'd0 : NES_PALETTE[iIndex];
    end

endmodule

// File: rtl/vga_line_scaler.sv
// Doubles a 256x240 NES picture onto a VGA raster using two ping-pong line banks
// refilled one NES line ahead of the beam.
module vga_line_scaler
    import vga_scaler_pkg::*;
#(
    parameter int LOOKAHEAD = 2,
    parameter int X_OFFSET  = X_OFFSET_DEF
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [10:0] iCurrent_X,
    input  logic [10:0] iCurrent_Y,
    input  logic        iRequest,
    input  logic        iVGA_VS,
    output logic        oLine_Req,
    output logic [7:0]  oLine_Num,
    input  logic        iPix_Valid,
    input  logic [5:0]  iPix_Data,
    output logic [9:0]  oRed,
    output logic [9:0]  oGreen,
    output logic [9:0]  oBlue,
    output logic        oOverrun
);

    localparam logic [10:0] X_LO = 11'(X_OFFSET);
    localparam logic [10:0] X_HI = 11'(X_OFFSET + 2 * NES_W);

    fillState_t  state, stateNext;
    logic [7:0]  wrAddr, lineNum;
    logic        overrun, vsPrev, reqPrev;
    logic        vsFall, reqRise, trigger, wrEn;
    logic [9:0]  rowHalf;
    logic [7:0]  trigLine;

    logic [5:0]  bank0 [NES_W];
    logic [5:0]  bank1 [NES_W];

    logic [10:0] xr;
    logic        inRange, rdBank;
    logic [7:0]  rdAddr;
    logic [5:0]  pixData_p1;
    logic        vld_p1;
    logic [29:0] rgb_p2;

    // A VGA row pair 2n/2n+1 shows NES line n, so the first even row of a pair fetches line n+1
    always_comb begin
        rowHalf  = iCurrent_Y[10:1];
        vsFall   = vsPrev & ~iVGA_VS;
        reqRise  = iRequest & ~reqPrev & ~iCurrent_Y[0] & (rowHalf <= 10'(NES_H - 2));
        trigger  = vsFall | reqRise;
        trigLine = vsFall ? 8'd0 : rowHalf[7:0] + 8'd1;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        oLine_Req = 1'b0;
        wrEn      = 1'b0;
        case (state)
            IDLE: stateNext = IDLE;
            REQ: begin
                oLine_Req = 1'b1;
                stateNext = FILL;
            end
            FILL: begin
                if (iPix_Valid) begin
                    wrEn = 1'b1;
                    if (wrAddr == 8'(NES_W - 1))
                        stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        // A new trigger always wins: the line in progress is dropped
        if (trigger) begin
            stateNext = REQ;
            wrEn      = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wrAddr  <= '0;
            lineNum <= '0;
            overrun <= 1'b0;
            vsPrev  <= 1'b1;
            reqPrev <= 1'b0;
        end else begin
            vsPrev  <= iVGA_VS;
            reqPrev <= iRequest;
            if (trigger) begin
                lineNum <= trigLine;
                wrAddr  <= '0;
                if (state != IDLE)
                    overrun <= 1'b1;
            end else if (wrEn) begin
                wrAddr <= wrAddr + 8'd1;
            end
        end
    end

    assign oLine_Num = lineNum;
    assign oOverrun  = overrun;

    always_ff @(posedge iCLK) begin
        if (wrEn && !lineNum[0])
            bank0[wrAddr] <= iPix_Data;
        if (wrEn && lineNum[0])
            bank1[wrAddr] <= iPix_Data;
    end

    always_comb begin
        xr      = iCurrent_X + 11'(LOOKAHEAD);
        inRange = (xr >= X_LO) && (xr < X_HI);
        rdAddr  = 8'((xr - X_LO) >> 1);
        rdBank  = iCurrent_Y[1];
    end

    // Stage 1: bank read and blank flag
    always_ff @(posedge iCLK) begin
        pixData_p1 <= rdBank ? bank1[rdAddr] : bank0[rdAddr];
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= iRequest & inRange;
    end

    // Stage 2: palette lookup into the colour outputs
    nes_palette_rom u_palette (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iIndex (pixData_p1),
        .iBlank (~vld_p1),
        .oRgb   (rgb_p2)
    );

    assign oRed   = rgb_p2[29:20];
    assign oGreen = rgb_p2[19:10];
    assign oBlue  = rgb_p2[9:0];

endmodule

// File: tb/tb_vga_line_scaler.sv
// Randomized self-checking bench for vga_line_scaler against a line-bank reference model.
module tb_vga_line_scaler;
    import vga_scaler_pkg::*;

    logic        clk = 1'b0;
    logic        iRST_N;
    logic [10:0] iCurrent_X, iCurrent_Y;
    logic        iRequest, iVGA_VS, iPix_Valid;
    logic [5:0]  iPix_Data;
    logic        oLine_Req, oOverrun;
    logic [7:0]  oLine_Num;
    logic [9:0]  oRed, oGreen, oBlue;

    int errors = 0;
    int checks = 0;

    logic [5:0] refBank [2][256];
    logic [5:0] lineBuf [256];

    localparam logic [29:0] PAL16 = {10'h3E3, 10'h0E0, 10'h000};

    vga_line_scaler dut (
        .iCLK       (clk),
        .iRST_N     (iRST_N),
        .iCurrent_X (iCurrent_X),
        .iCurrent_Y (iCurrent_Y),
        .iRequest   (iRequest),
        .iVGA_VS    (iVGA_VS),
        .oLine_Req  (oLine_Req),
        .oLine_Num  (oLine_Num),
        .iPix_Valid (iPix_Valid),
        .iPix_Data  (iPix_Data),
        .oRed       (oRed),
        .oGreen     (oGreen),
        .oBlue      (oBlue),
        .oOverrun   (oOverrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: VGA column x shows NES pixel (x-64)/2 of line y/2, two clocks later
    function automatic logic [29:0] expColor(input int x, input int y, input bit req);
        int xr;
        xr = (x + 2) % 2048;
        if (!req || xr < 64 || xr >= 64 + 512)
            return 30'd0;
        return NES_PALETTE[refBank[(y / 2) % 2][(xr - 64) / 2]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (oLine_Req) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic rand_line();
        for (int i = 0; i < 256; i++)
            lineBuf[i] = 6'($urandom_range(0, 63));
    endtask

    task automatic send_beats(input int n, input int bnk, input bit record);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                iPix_Valid = 1'b0;
                iPix_Data  = 6'($urandom_range(0, 63));
                tick();
            end
            iPix_Valid = 1'b1;
            iPix_Data  = lineBuf[i];
            tick();
        end
        iPix_Valid = 1'b0;
        if (record)
            for (int i = 0; i < n; i++)
                refBank[bnk][i] = lineBuf[i];
    endtask

    task automatic scan_row(input int y);
        logic [29:0] ePrev, eCur;
        bit have;
        have = 1'b0;
        ePrev = '0;
        iCurrent_Y = 11'(y);
        for (int x = 0; x < 640; x++) begin
            iCurrent_X = 11'(x);
            iRequest   = ($urandom_range(0, 4) != 0);
            eCur       = expColor(x, y, iRequest);
            tick();
            if (have) begin
                checks++;
                if ({oRed, oGreen, oBlue} !== ePrev) begin
                    errors++;
                    $display("FAIL scan y=%0d x=%0d got %h expected %h", y, x - 1, {oRed, oGreen, oBlue}, ePrev);
                end
            end
            ePrev = eCur;
            have  = 1'b1;
        end
        iRequest   = 1'b0;
        iCurrent_X = '0;
        tick();
        checks++;
        if ({oRed, oGreen, oBlue} !== ePrev) begin
            errors++;
            $display("FAIL scan y=%0d x=639 got %h expected %h", y, {oRed, oGreen, oBlue}, ePrev);
        end
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        repeat (3) tick();
        checks++;
        if ({oLine_Req, oLine_Num, oOverrun} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctrl got req=%b num=%0d ovr=%b expected all 0", oLine_Req, oLine_Num, oOverrun);
        end
        checks++;
        if ({oRed, oGreen, oBlue} !== 30'd0) begin
            errors++;
            $display("FAIL reset_rgb got %h expected 0", {oRed, oGreen, oBlue});
        end
        iRST_N = 1'b1;
        repeat (3) tick();
        checks++;
        if (oLine_Req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_req got %b expected 0", oLine_Req);
        end
    endtask

    task automatic test_vs_fill();
        bit seen;
        iVGA_VS = 1'b0;
        wait_req(seen);
        checks++;
        if (seen !== 1'b1 || oLine_Num !== 8'd0) begin
            errors++;
            $display("FAIL vs_req got seen=%b num=%0d expected seen=1 num=0", seen, oLine_Num);
        end
        tick();
        checks++;
        if (oLine_Req !== 1'b0) begin
            errors++;
            $display("FAIL vs_req_pulse got %b expected 0", oLine_Req);
        end
        for (int i = 0; i < 256; i++) lineBuf[i] = 6'h16;
        send_beats(256, 0, 1'b1);
        // beats after the line is complete must not land anywhere
        iPix_Valid = 1'b1;
        iPix_Data  = 6'h3F;
        repeat (10) tick();
        iPix_Valid = 1'b0;
        iVGA_VS    = 1'b1;
        tick();
        checks++;
        if (oOverrun !== 1'b0) begin
            errors++;
            $display("FAIL vs_overrun got %b expected 0", oOverrun);
        end
    endtask

    task automatic test_pixel_align();
        int          xs   [8] = '{61, 62, 63, 573, 574, 576, 10, 62};
        bit          rq   [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        logic [29:0] ex   [8] = '{30'd0, PAL16, PAL16, PAL16, 30'd0, 30'd0, 30'd0, 30'd0};
        iCurrent_Y = 11'd1;
        iCurrent_X = 11'd0;
        iRequest   = 1'b1;
        tick();
        iCurrent_Y = 11'd0;
        for (int i = 0; i < 8; i++) begin
            iCurrent_X = 11'(xs[i]);
            iRequest   = rq[i];
            tick();
            if (i > 0) begin
                checks++;
                if ({oRed, oGreen, oBlue} !== ex[i - 1]) begin
                    errors++;
                    $display("FAIL align x=%0d req=%b got %h expected %h", xs[i - 1], rq[i - 1], {oRed, oGreen, oBlue}, ex[i - 1]);
                end
            end
        end
        tick();
        checks++;
        if ({oRed, oGreen, oBlue} !== ex[7]) begin
            errors++;
            $display("FAIL align x=62 req=0 got %h expected %h", {oRed, oGreen, oBlue}, ex[7]);
        end
        scan_row(1);
    endtask

    task automatic test_trigger();
        bit seen;
        iRequest = 1'b0;
        tick();
        iCurrent_Y = 11'd478;
        iRequest   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (oLine_Req) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL y478_no_req got request=%b expected 0", seen);
        end
        iRequest = 1'b0;
        tick();
        iCurrent_Y = 11'd2;
        iRequest   = 1'b1;
        wait_req(seen);
        checks++;
        if (seen !== 1'b1 || oLine_Num !== 8'd2) begin
            errors++;
            $display("FAIL y2_req got seen=%b num=%0d expected seen=1 num=2", seen, oLine_Num);
        end
        tick();
        rand_line();
        send_beats(256, 0, 1'b1);
        iRequest = 1'b0;
        tick();
        scan_row(5);
        iCurrent_Y = 11'd476;
        iRequest   = 1'b1;
        wait_req(seen);
        checks++;
        if (seen !== 1'b1 || oLine_Num !== 8'd239) begin
            errors++;
            $display("FAIL y476_req got seen=%b num=%0d expected seen=1 num=239", seen, oLine_Num);
        end
        tick();
        rand_line();
        send_beats(256, 1, 1'b1);
        iRequest = 1'b0;
        tick();
        scan_row(479);
        checks++;
        if (oOverrun !== 1'b0) begin
            errors++;
            $display("FAIL trig_overrun got %b expected 0", oOverrun);
        end
    endtask

    task automatic test_overrun();
        bit seen;
        iCurrent_Y = 11'd4;
        iRequest   = 1'b1;
        wait_req(seen);
        checks++;
        if (seen !== 1'b1 || oLine_Num !== 8'd3) begin
            errors++;
            $display("FAIL ovr_first_req got seen=%b num=%0d expected seen=1 num=3", seen, oLine_Num);
        end
        tick();
        rand_line();
        send_beats(100, 1, 1'b0);
        iRequest = 1'b0;
        tick();
        iCurrent_Y = 11'd6;
        iRequest   = 1'b1;
        wait_req(seen);
        checks++;
        if (seen !== 1'b1 || oLine_Num !== 8'd4 || oOverrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_second_req got seen=%b num=%0d ovr=%b expected seen=1 num=4 ovr=1", seen, oLine_Num, oOverrun);
        end
        tick();
        checks++;
        if (oLine_Req !== 1'b0) begin
            errors++;
            $display("FAIL ovr_req_pulse got %b expected 0", oLine_Req);
        end
        rand_line();
        send_beats(256, 0, 1'b1);
        iRequest = 1'b0;
        tick();
        scan_row(9);
        checks++;
        if (oOverrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky got %b expected 1", oOverrun);
        end
    endtask

    task automatic test_reset_mid_fill();
        bit seen;
        iCurrent_Y = 11'd2;
        iRequest   = 1'b1;
        wait_req(seen);
        checks++;
        if (seen !== 1'b1 || oLine_Num !== 8'd2) begin
            errors++;
            $display("FAIL mid_req got seen=%b num=%0d expected seen=1 num=2", seen, oLine_Num);
        end
        tick();
        rand_line();
        send_beats(50, 0, 1'b0);
        iCurrent_Y = 11'd1;
        iCurrent_X = 11'd70;
        repeat (2) tick();
        iRequest = 1'b0;
        iRST_N   = 1'b0;
        #1;
        checks++;
        if ({oLine_Req, oLine_Num, oOverrun} !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_ctrl got req=%b num=%0d ovr=%b expected all 0", oLine_Req, oLine_Num, oOverrun);
        end
        checks++;
        if ({oRed, oGreen, oBlue} !== 30'd0) begin
            errors++;
            $display("FAIL mid_reset_rgb got %h expected 0", {oRed, oGreen, oBlue});
        end
        repeat (2) tick();
        iRST_N = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            iPix_Valid = ($urandom_range(0, 1) != 0);
            iPix_Data  = 6'($urandom_range(0, 63));
            tick();
            if (oLine_Req) seen = 1'b1;
        end
        iPix_Valid = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_release_req got request=%b expected 0", seen);
        end
        iVGA_VS = 1'b0;
        wait_req(seen);
        checks++;
        if (seen !== 1'b1 || oLine_Num !== 8'd0) begin
            errors++;
            $display("FAIL mid_vs_req got seen=%b num=%0d expected seen=1 num=0", seen, oLine_Num);
        end
        tick();
        rand_line();
        send_beats(256, 0, 1'b1);
        iVGA_VS = 1'b1;
        tick();
        scan_row(1);
        checks++;
        if (oOverrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_overrun got %b expected 0", oOverrun);
        end
    endtask

    initial begin
        iRST_N     = 1'b0;
        iCurrent_X = '0;
        iCurrent_Y = 11'd1;
        iRequest   = 1'b0;
        iVGA_VS    = 1'b1;
        iPix_Valid = 1'b0;
        iPix_Data  = '0;
        test_reset();
        test_vs_fill();
        test_pixel_align();
        test_trigger();
        test_overrun();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_line_scaler.md
VGA_LINE_SCALER -- requirements
Module: vga_line_scaler

Interface
REQ-001 SHALL have parameter LOOKAHEAD, default 2, meaning pixel clocks of read latency compensated for internally.
REQ-002 SHALL have parameter X_OFFSET, default 64, meaning first active VGA column showing NES pixel 0.
REQ-003 SHALL have port iCLK, input, 1, VGA pixel clock, the single clock domain; all logic on its rising edge.
REQ-004 SHALL have port iRST_N, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port iCurrent_X, input, 11, active-area column from the VGA controller (0 during blanking).
REQ-006 SHALL have port iCurrent_Y, input, 11, active-area row from the VGA controller (0 during blanking).
REQ-007 SHALL have port iRequest, input, 1, high while the VGA controller is in the active area.
REQ-008 SHALL have port iVGA_VS, input, 1, vertical sync from the VGA controller, active-low.
REQ-009 SHALL have port oLine_Req, output, 1, one-cycle pulse asking upstream for NES line oLine_Num.
REQ-010 SHALL have port oLine_Num, output, 8, NES line (0..239) being requested.
REQ-011 SHALL have port iPix_Valid, input, 1, qualifies iPix_Data.
REQ-012 SHALL have port iPix_Data, input, 6, NES palette index.
REQ-013 SHALL have ports oRed, oGreen and oBlue, output, 10 each, colour to the VGA controller.
REQ-014 SHALL have port oOverrun, output, 1, sticky error flag.

Function
REQ-015 SHALL map the 256x240 NES image 2x in both axes into VGA columns X_OFFSET..X_OFFSET+511 and rows 0..479; all other active columns SHALL be black (0).
REQ-016 SHALL hold two 256x6 line banks; NES line n SHALL be written to and read from bank n[0].
REQ-017 SHALL run a fill FSM with states IDLE, REQ and FILL: IDLE->REQ on a trigger; REQ asserts oLine_Req for one cycle and goes to FILL; FILL writes each iPix_Valid beat to address 0,1,..255 and returns to IDLE after beat 255.
REQ-018 SHALL trigger a fill of line 0 on the falling edge of iVGA_VS.
REQ-019 SHALL trigger a fill of line n+1 on the rising edge of iRequest when iCurrent_Y is even and n=iCurrent_Y/2 is at most 238; no fill SHALL be triggered for n=239.
REQ-020 SHALL ignore iPix_Valid outside FILL.
REQ-021 SHALL set oOverrun when a trigger occurs in REQ or FILL, abandon the current fill, and restart in REQ with the new line number; oOverrun SHALL clear only on reset.
REQ-022 SHALL compute the read column as xr=iCurrent_X+LOOKAHEAD with 11-bit arithmetic, so that output colour aligns with the undelayed iCurrent_X stream.
REQ-023 SHALL set the NES pixel to (xr-X_OFFSET)>>1 when X_OFFSET<=xr<X_OFFSET+512, and treat xr outside that range as border.
REQ-024 SHALL use a 2-stage read pipeline: stage 1 registers the bank RAM read and a border/blank flag; stage 2 registers the palette lookup into oRed/oGreen/oBlue.
REQ-025 SHALL output black when iRequest was low or the pixel was border, both evaluated at stage 1.
REQ-026 SHALL allow a bank read and a write to the other bank in the same cycle; a same-bank same-address collision SHALL return the old data.

Reset
REQ-027 SHALL, on iRST_N low, force: FSM IDLE, write address 0, oLine_Req=0, oLine_Num=0, oOverrun=0, oRed=oGreen=oBlue=0, pipeline flags black, and edge detectors primed to the inactive level (iVGA_VS=1, iRequest=0).
REQ-028 SHALL NOT reset bank RAM contents.
REQ-029 SHALL, on reset asserted during FILL, leave no pending request after release.

Structure
REQ-030 SHALL place X_OFFSET default, NES_W=256, NES_H=240, the 64x30-bit NES palette constant table and the FSM state type in package vga_scaler_pkg.
REQ-031 SHALL implement the palette lookup as sub-module nes_palette_rom (6-bit address in, registered 30-bit RGB out).

Verification
REQ-032 SHALL cover: VS falling edge -> oLine_Req pulse with oLine_Num=0; 256 beats of index 0x16 -> bank 0 filled and FSM IDLE.
REQ-033 SHALL cover: iCurrent_X=62, row 0 active, pixel 0=0x16 -> two cycles later oRed/oGreen/oBlue show the palette entry for 0x16; with iCurrent_X=63 the same entry is shown for the duplicated pixel.
REQ-034 SHALL cover: iCurrent_X=576 and iCurrent_X=10 -> output 0; iRequest low -> output 0.
REQ-035 SHALL cover: iRequest rising at Y=478 -> no oLine_Req; at Y=2 -> oLine_Num=2 into bank 0.
REQ-036 SHALL cover: a second trigger after only 100 beats -> oOverrun=1, new oLine_Req issued, and the refill completes correctly.
REQ-037 SHALL cover: iRST_N asserted mid-FILL -> all outputs 0 immediately; after release, no oLine_Req until the next trigger.
